// File: rtl/switch_debounce.sv
// Push-button debouncer: synchroniser, qualification counter and
// registered rise/fall strobes on the clean level.
module switch_debounce #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Rise,
  output logic o_Fall
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sw_q, sw_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;
  logic                   commit;

  assign s      = sync_q[SYNC_STAGES-1];
  assign commit = (s != sw_q) && (cnt_q == LAST);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_Switch};
    cnt_d  = '0;
    // any disagreement-free cycle restarts qualification
    if (s != sw_q && !commit) cnt_d = cnt_q + CW'(1);
    sw_d   = commit ? s : sw_q;
    rise_d = commit & s;
    fall_d = commit & ~s;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q <= '0;
      cnt_q  <= '0;
      sw_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      sw_q   <= sw_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o_Switch = sw_q;
  assign o_Rise   = rise_q;
  assign o_Fall   = fall_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: expected strobe events are queued when
// stimulus is driven and matched as the DUT emits them.
module tb_switch_debounce;

  typedef struct {
    bit rise;
    int at;
  } ev_t;

  logic clk;
  logic rst_n;
  logic sw_a, sw_b;
  logic a_sw, a_rise, a_fall;
  logic b_sw, b_rise, b_fall;

  int   cyc;
  int   checks;
  int   errors;
  ev_t  qa[$];
  ev_t  qb[$];

  switch_debounce #(.DEBOUNCE_LIMIT(8), .SYNC_STAGES(2)) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw_a),
    .o_Switch(a_sw), .o_Rise(a_rise), .o_Fall(a_fall)
  );

  switch_debounce #(.DEBOUNCE_LIMIT(1), .SYNC_STAGES(2)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw_b),
    .o_Switch(b_sw), .o_Rise(b_rise), .o_Fall(b_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_a(input bit r, input int at);
    ev_t e;
    e.rise = r;
    e.at   = at;
    qa.push_back(e);
  endtask

  task automatic push_b(input bit r, input int at);
    ev_t e;
    e.rise = r;
    e.at   = at;
    qb.push_back(e);
  endtask

  // one clock edge, then match any strobes against the queues
  task automatic step();
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (a_rise || a_fall) begin
      checks++;
      if ((a_rise & a_fall) !== 1'b0) begin
        errors++;
        $display("FAIL a_both_strobes cyc=%0d got rise=%b fall=%b want not both",
                 cyc, a_rise, a_fall);
      end
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_strobe cyc=%0d got rise=%b fall=%b want none",
                 cyc, a_rise, a_fall);
      end else begin
        e = qa.pop_front();
        if (a_rise !== e.rise || cyc != e.at) begin
          errors++;
          $display("FAIL a_event got rise=%b at %0d want rise=%b at %0d",
                   a_rise, cyc, e.rise, e.at);
        end
      end
    end
    if (b_rise || b_fall) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_strobe cyc=%0d got rise=%b fall=%b want none",
                 cyc, b_rise, b_fall);
      end else begin
        e = qb.pop_front();
        if (b_rise !== e.rise || cyc != e.at) begin
          errors++;
          $display("FAIL b_event got rise=%b at %0d want rise=%b at %0d",
                   b_rise, cyc, e.rise, e.at);
        end
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input string name);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing got pending a=%0d b=%0d want 0 0",
               name, qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  task automatic check_lvl(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({a_sw, a_rise, a_fall, b_sw, b_rise, b_fall} !== 6'b0) begin
      errors++;
      $display("FAIL %s got a=%b%b%b b=%b%b%b want all 0", name,
               a_sw, a_rise, a_fall, b_sw, b_rise, b_fall);
    end
  endtask

  task automatic test_reset_init();
    rst_n = 1'b0;
    sw_a  = 1'b0;
    sw_b  = 1'b0;
    #2;
    check_zero("reset_state");
    steps(3);
    check_zero("reset_held");
    rst_n = 1'b1;
    steps(4);
    check_zero("after_release");
  endtask

  task automatic test_clean_press();
    int t0;
    sw_a = 1'b1;
    t0 = cyc;
    push_a(1'b1, t0 + 10);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 9)  check_lvl("press_before", a_sw, 1'b0);
      if (k == 10) check_lvl("press_at10", a_sw, 1'b1);
    end
    check_lvl("press_held", a_sw, 1'b1);
    drain("clean_press");
  endtask

  task automatic test_reset_async();
    int t0;
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_clear");
    steps(3);
    check_zero("reset_hold_hi");
    rst_n = 1'b1;
    t0 = cyc;
    push_a(1'b1, t0 + 10);
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 9)  check_lvl("rel_before", a_sw, 1'b0);
      if (k == 10) check_lvl("rel_at10", a_sw, 1'b1);
    end
    drain("reset_release");
  endtask

  task automatic test_release_bounce();
    int t0;
    sw_a = 1'b0; steps(3);
    sw_a = 1'b1; steps(2);
    sw_a = 1'b0; steps(4);
    sw_a = 1'b1; steps(1);
    sw_a = 1'b0;
    t0 = cyc;
    push_a(1'b0, t0 + 10);
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 9)  check_lvl("fall_before", a_sw, 1'b1);
      if (k == 10) check_lvl("fall_at10", a_sw, 1'b0);
    end
    drain("release_bounce");
  endtask

  task automatic test_press_bounce();
    int t0;
    sw_a = 1'b1; steps(5);
    sw_a = 1'b0; steps(2);
    sw_a = 1'b1; steps(3);
    sw_a = 1'b0; steps(1);
    sw_a = 1'b1;
    t0 = cyc;
    push_a(1'b1, t0 + 10);
    steps(14);
    drain("press_bounce");
    sw_a = 1'b0;
    t0 = cyc;
    push_a(1'b0, t0 + 10);
    steps(14);
    drain("back_to_back");
  endtask

  task automatic test_glitch();
    int t0;
    sw_a = 1'b1; steps(7);
    sw_a = 1'b0; steps(15);
    check_lvl("glitch7_level", a_sw, 1'b0);
    drain("glitch7");
    sw_a = 1'b1;
    t0 = cyc;
    push_a(1'b1, t0 + 10);
    push_a(1'b0, t0 + 18);
    steps(8);
    sw_a = 1'b0;
    steps(17);
    drain("glitch8");
  endtask

  task automatic test_reset_midcount();
    int t0;
    sw_a = 1'b1;
    steps(7);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("mid_clear");
    steps(2);
    rst_n = 1'b1;
    t0 = cyc;
    push_a(1'b1, t0 + 10);
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 9) check_lvl("mid_before", a_sw, 1'b0);
    end
    drain("reset_midcount");
    sw_a = 1'b0;
    push_a(1'b0, cyc + 10);
    steps(14);
    drain("mid_fall");
  endtask

  task automatic test_limit1();
    int t0;
    sw_b = 1'b1;
    t0 = cyc;
    push_b(1'b1, t0 + 3);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 2) check_lvl("lim1_before", b_sw, 1'b0);
      if (k == 3) check_lvl("lim1_at3", b_sw, 1'b1);
    end
    sw_b = 1'b0;
    push_b(1'b0, cyc + 3);
    steps(6);
    check_lvl("lim1_low", b_sw, 1'b0);
    drain("limit1");
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    test_reset_init();
    test_clean_press();
    test_reset_async();
    test_release_bounce();
    test_press_bounce();
    test_glitch();
    test_reset_midcount();
    test_limit1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
